pc_predict_unit: RTL and testbench

Fetch-stage program-counter unit for the pipelined LEGv8 core, and the successor of the single-cycle next-PC path. It holds the PC register and predicts the next PC through a parametrised direct-mapped branch target buffer (BTB). It also resolves branches arriving from a later stage: B, CBZ/B.cond, BR and sequential. On a misprediction it raises a flush and redirects the PC.

---
 rtl/pc_predict_unit_pkg.sv | 34 +++
 rtl/pc_predict_unit_if.sv | 41 ++++
 rtl/pc_predict_unit_btb_dm.sv | 70 +++++++
 rtl/pc_predict_unit.sv | 121 ++++++++++++
 tb/tb_pc_predict_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_predict_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg: shared types and helpers for the fetch-stage PC prediction unit.
//   br_mode_e  - how a resolving instruction computes its successor PC.
//   sext_shift - sign-extends a word-granular branch offset and scales it to
//                a byte offset.
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    BR_SEQ    = 2'b00,  // fall-through
    BR_COND   = 2'b01,  // CBZ / B.cond, Imm19
    BR_UNCOND = 2'b10,  // B, Imm26
    BR_REG    = 2'b11   // BR, register target
  } br_mode_e;

  // Widest PC the offset helper produces; ADDR_W must not exceed this.
  localparam int unsigned MAX_ADDR_W = 64;

  // Treat imm[imm_w-1:0] as a signed word offset and return it as a byte
  // offset (sign-extended to MAX_ADDR_W, shifted left by 'shift').
  function automatic logic [MAX_ADDR_W-1:0] sext_shift(
    input logic [25:0]  imm,
    input int unsigned  imm_w,
    input int unsigned  shift
  );
    logic [MAX_ADDR_W-1:0] ext;
    logic [MAX_ADDR_W-1:0] hi_mask;
    hi_mask = {MAX_ADDR_W{1'b1}} << imm_w;
    ext     = {{(MAX_ADDR_W - 26){1'b0}}, imm} & ~hi_mask;
    if (imm[imm_w - 1]) ext = ext | hi_mask;
    return ext << shift;
  endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// -----------------------------------------------------------------------------
// pc_predict_unit_if: fetch/resolve bus of the PC prediction unit.
//   slave  - the unit: consumes stall and the resolve bundle, drives the fetch
//            PC, its prediction, the BTB hit flag, flush and the counter.
//   master - the pipeline around it (or a testbench).
// -----------------------------------------------------------------------------
interface pc_predict_unit_if
  import pc_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);

  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pred_next;
  logic              btb_hit;
  logic              res_valid;
  logic [ADDR_W-1:0] res_pc;
  logic [ADDR_W-1:0] res_pred_next;
  br_mode_e          res_mode;
  logic              res_cond_taken;
  logic [18:0]       res_imm19;
  logic [25:0]       res_imm26;
  logic [ADDR_W-1:0] res_db;
  logic              flush;
  logic [CNT_W-1:0]  mispredict_cnt;

  modport master (
    output stall, res_valid, res_pc, res_pred_next, res_mode,
           res_cond_taken, res_imm19, res_imm26, res_db,
    input  pc, pred_next, btb_hit, flush, mispredict_cnt
  );

  modport slave (
    input  stall, res_valid, res_pc, res_pred_next, res_mode,
           res_cond_taken, res_imm19, res_imm26, res_db,
    output pc, pred_next, btb_hit, flush, mispredict_cnt
  );

endinterface

// File: rtl/pc_predict_unit_btb_dm.sv
// -----------------------------------------------------------------------------
// btb_dm: direct-mapped branch target buffer, addressed by word address
// (byte PC with the instruction-alignment bits already dropped).
//   clk, rst_n       - clock, asynchronous active-low clear of all valid bits
//   rd_wa_i          - lookup word address (combinational read)
//   rd_hit_o         - entry valid and tag matches
//   rd_target_o      - stored target of the indexed entry
//   wr_en_i          - allocate/overwrite entry for upd_wa_i with upd_target_i
//   inv_en_i         - invalidate entry for upd_wa_i if its tag matches
//   upd_wa_i         - word address of the resolving instruction
//   upd_target_i     - byte target to store
// DEPTH must be a power of two in 2..64.
// -----------------------------------------------------------------------------
module btb_dm #(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 8,
  parameter int WA_W   = 62
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WA_W-1:0]   rd_wa_i,
  output logic              rd_hit_o,
  output logic [ADDR_W-1:0] rd_target_o,
  input  logic              wr_en_i,
  input  logic              inv_en_i,
  input  logic [WA_W-1:0]   upd_wa_i,
  input  logic [ADDR_W-1:0] upd_target_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = WA_W - IDX_W;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];

  logic [IDX_W-1:0]  rd_idx, upd_idx;
  logic [TAG_W-1:0]  rd_tag, upd_tag;

  assign rd_idx  = rd_wa_i[IDX_W-1:0];
  assign rd_tag  = rd_wa_i[WA_W-1:IDX_W];
  assign upd_idx = upd_wa_i[IDX_W-1:0];
  assign upd_tag = upd_wa_i[WA_W-1:IDX_W];

  // Reads see the contents before any same-cycle write (no bypass).
  assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target_o = target_q[rd_idx];

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the asynchronous clear sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[upd_idx] <= 1'b1;
    end else if (inv_en_i && (tag_q[upd_idx] == upd_tag)) begin
      valid_q[upd_idx] <= 1'b0;
    end
  end

  // NOTE: tag/target arrays are deliberately not reset; a cleared valid bit
  // makes their contents irrelevant and keeps them plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target_i;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// -----------------------------------------------------------------------------
// pc_predict_unit: fetch-stage PC register with BTB next-PC prediction and
// late-stage branch resolution for the pipelined LEGv8 core.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - pc_predict_unit_if.slave:
//             stall                       hold PC (a flush overrides it)
//             pc / pred_next / btb_hit    fetch PC and its prediction
//             res_*                       resolving instruction bundle
//             flush                       same-cycle misprediction flag
//             mispredict_cnt              saturating misprediction count
// ADDR_W must not exceed pc_pkg::MAX_ADDR_W.
// -----------------------------------------------------------------------------
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                BTB_DEPTH   = 8,
  parameter int                INSTR_SHIFT = 2,
  parameter int                CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  pc_predict_unit_if.slave bus
);

  localparam int                WA_W = ADDR_W - INSTR_SHIFT;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(1) << INSTR_SHIFT;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              btb_hit;
  logic [ADDR_W-1:0] btb_target;
  logic [ADDR_W-1:0] pred_next;

  logic [ADDR_W-1:0] seq_pc, off19, off26, actual_next;
  logic              taken, flush;

  // ---------------------------------------------------------------------------
  // Prediction
  // ---------------------------------------------------------------------------
  btb_dm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (BTB_DEPTH),
    .WA_W   (WA_W)
  ) u_btb (
    .clk          (clk),
    .rst_n        (reset),
    .rd_wa_i      (pc_q[ADDR_W-1:INSTR_SHIFT]),
    .rd_hit_o     (btb_hit),
    .rd_target_o  (btb_target),
    .wr_en_i      (bus.res_valid && taken),
    .inv_en_i     (bus.res_valid && (bus.res_mode == BR_COND) && !bus.res_cond_taken),
    .upd_wa_i     (bus.res_pc[ADDR_W-1:INSTR_SHIFT]),
    .upd_target_i (actual_next)
  );

  assign pred_next = btb_hit ? btb_target : pc_q + STEP;

  // ---------------------------------------------------------------------------
  // Resolution (all sums wrap modulo 2^ADDR_W)
  // ---------------------------------------------------------------------------
  assign seq_pc = bus.res_pc + STEP;
  assign off19  = ADDR_W'(sext_shift(26'(bus.res_imm19), 19, INSTR_SHIFT));
  assign off26  = ADDR_W'(sext_shift(bus.res_imm26, 26, INSTR_SHIFT));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    actual_next = seq_pc;
    taken       = 1'b0;
    unique case (bus.res_mode)
      BR_SEQ: ;
      BR_COND: begin
        taken = bus.res_cond_taken;
        if (bus.res_cond_taken) actual_next = bus.res_pc + off19;
      end
      BR_UNCOND: begin
        taken       = 1'b1;
        actual_next = bus.res_pc + off26;
      end
      BR_REG: begin
        taken       = 1'b1;
        actual_next = bus.res_db;  // used verbatim, no alignment check
      end
      default: ;
    endcase
  end

  assign flush = bus.res_valid && (actual_next != bus.res_pred_next);

  // ---------------------------------------------------------------------------
  // PC and counter state
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d = pred_next;
    if (flush)          pc_d = actual_next;
    else if (bus.stall) pc_d = pc_q;
  end

  assign cnt_d = (flush && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pred_next      = pred_next;
  assign bus.btb_hit        = btb_hit;
  assign bus.flush          = flush;
  assign bus.mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_predict_unit: directed bench for pc_predict_unit. A table of resolve
// vectors (applied with stall held so the PC only moves on a flush) plus
// hand-written sequences for BTB fill/invalidate, stall, reset and wrap.
// A second instance with RESET_PC near the top of memory and a 2-bit counter
// covers PC wrap-around and counter saturation.
// -----------------------------------------------------------------------------
module tb_pc_predict_unit;
  import pc_pkg::*;

  logic clk;
  logic reset;

  pc_predict_unit_if #(.ADDR_W(64), .CNT_W(32)) bus  ();
  pc_predict_unit_if #(.ADDR_W(64), .CNT_W(2))  bus2 ();

  pc_predict_unit #(
    .ADDR_W(64), .RESET_PC(64'h0), .BTB_DEPTH(8), .INSTR_SHIFT(2), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  pc_predict_unit #(
    .ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .BTB_DEPTH(8),
    .INSTR_SHIFT(2), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input br_mode_e m, input logic [63:0] rpc,
                       input logic [63:0] pred, input logic tk, input logic [18:0] i19,
                       input logic [25:0] i26, input logic [63:0] db);
    bus.res_valid      = v;
    bus.res_mode       = m;
    bus.res_pc         = rpc;
    bus.res_pred_next  = pred;
    bus.res_cond_taken = tk;
    bus.res_imm19      = i19;
    bus.res_imm26      = i26;
    bus.res_db         = db;
  endtask

  task automatic drive_br(input logic [63:0] rpc, input logic [63:0] db, input logic [63:0] pred);
    drive(1'b1, BR_REG, rpc, pred, 1'b0, '0, '0, db);
  endtask

  task automatic idle();
    drive(1'b0, BR_SEQ, '0, '0, 1'b0, '0, '0, '0);
  endtask

  typedef struct {
    logic        v;
    br_mode_e    mode;
    logic [63:0] rpc;
    logic [63:0] pred;
    logic        tk;
    logic [18:0] i19;
    logic [25:0] i26;
    logic [63:0] db;
    logic        exp_flush;
    logic [63:0] exp_pc;
    logic [31:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input br_mode_e m, input logic [63:0] rpc,
                              input logic [63:0] pred, input logic tk, input logic [18:0] i19,
                              input logic [25:0] i26, input logic [63:0] db, input logic ef,
                              input logic [63:0] epc, input logic [31:0] ecnt);
    vec_t r;
    r.v = v; r.mode = m; r.rpc = rpc; r.pred = pred; r.tk = tk; r.i19 = i19;
    r.i26 = i26; r.db = db; r.exp_flush = ef; r.exp_pc = epc; r.exp_cnt = ecnt;
    return r;
  endfunction

  vec_t vecs [12];

  initial begin
    // Stall is held throughout the table: PC moves only when a row flushes.
    vecs[0]  = mk(1, BR_SEQ,    64'h1000, 64'h1004, 0, 19'h0, 26'h0, 64'h0, 0, 64'h800, 6);
    vecs[1]  = mk(1, BR_SEQ,    64'h1000, 64'h2000, 0, 19'h0, 26'h0, 64'h0, 1, 64'h1004, 7);
    vecs[2]  = mk(1, BR_COND,   64'h2000, 64'h200C, 1, 19'h3, 26'h0, 64'h0, 0, 64'h1004, 7);
    vecs[3]  = mk(1, BR_COND,   64'h2000, 64'h200C, 0, 19'h3, 26'h0, 64'h0, 1, 64'h2004, 8);
    vecs[4]  = mk(1, BR_UNCOND, 64'h3000, 64'h2FFC, 0, 19'h0, 26'h3FF_FFFF, 64'h0, 0, 64'h2004, 8);
    vecs[5]  = mk(1, BR_UNCOND, 64'h3000, 64'h0,    0, 19'h0, 26'h200_0000, 64'h0, 1,
                  64'hFFFF_FFFF_F800_3000, 9);
    vecs[6]  = mk(1, BR_REG,    64'h5000, 64'h124,  0, 19'h0, 26'h0, 64'h123, 1, 64'h123, 10);
    vecs[7]  = mk(1, BR_REG,    64'h5000, 64'h123,  0, 19'h0, 26'h0, 64'h123, 0, 64'h123, 10);
    vecs[8]  = mk(1, BR_COND,   64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 19'h1, 26'h0, 64'h0, 0, 64'h123, 10);
    vecs[9]  = mk(1, BR_UNCOND, 64'h4000, 64'h0,    0, 19'h0, 26'h1FF_FFFF, 64'h0, 1, 64'h800_3FFC, 11);
    vecs[10] = mk(1, BR_COND,   64'h10_0000, 64'h0, 1, 19'h4_0000, 26'h0, 64'h0, 0, 64'h800_3FFC, 11);
    vecs[11] = mk(0, BR_SEQ,    64'h1000, 64'h9999, 0, 19'h0, 26'h0, 64'h0, 0, 64'h800_3FFC, 11);

    reset     = 1'b0;
    bus.stall = 1'b0;
    idle();
    bus2.stall = 1'b0;
    bus2.res_valid = 1'b0; bus2.res_mode = BR_SEQ; bus2.res_pc = '0;
    bus2.res_pred_next = '0; bus2.res_cond_taken = 1'b0; bus2.res_imm19 = '0;
    bus2.res_imm26 = '0; bus2.res_db = '0;

    // Reset state
    #12;
    check("rst_pc", bus.pc, 64'h0);
    check("rst_hit", bus.btb_hit, 1'b0);
    check("rst_flush", bus.flush, 1'b0);
    check("rst_pred", bus.pred_next, 64'h4);
    check("rst_cnt", bus.mispredict_cnt, 32'h0);
    check("rst_pc2", bus2.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("rst_pred2", bus2.pred_next, 64'h0);
    reset = 1'b1;

    // Sequential fetch with an empty BTB; second instance wraps to 0
    step();
    check("seq_pc1", bus.pc, 64'h4);
    check("wrap_pc2", bus2.pc, 64'h0);
    check("wrap_flush2", bus2.flush, 1'b0);
    step();
    check("seq_pc2", bus.pc, 64'h8);
    check("seq_hit", bus.btb_hit, 1'b0);
    step();
    check("seq_pc3", bus.pc, 64'hC);
    check("seq_flush", bus.flush, 1'b0);
    repeat (13) step();
    check("seq_pc40", bus.pc, 64'h40);

    // Unconditional mispredict at pc=0x40
    drive(1'b1, BR_UNCOND, 64'h10, 64'h14, 1'b0, '0, 26'd4, '0);
    #1;
    check("b_flush", bus.flush, 1'b1);
    step();
    idle();
    check("b_pc", bus.pc, 64'h20);
    check("b_cnt", bus.mispredict_cnt, 32'd1);

    // Redirect to 0x10 and see the learned target
    drive_br(64'h200, 64'h10, 64'h0);
    step();
    idle();
    check("b_fetch_pc", bus.pc, 64'h10);
    check("b_hit", bus.btb_hit, 1'b1);
    check("b_pred", bus.pred_next, 64'h20);
    step();
    check("b_follow", bus.pc, 64'h20);

    // Conditional taken backwards, then not taken at the same PC
    drive(1'b1, BR_COND, 64'h100, 64'h104, 1'b1, 19'h7FFFE, '0, '0);
    #1;
    check("cb_flush", bus.flush, 1'b1);
    step();
    idle();
    check("cb_pc", bus.pc, 64'hF8);
    check("cb_cnt", bus.mispredict_cnt, 32'd3);
    step();
    step();
    check("cb_pc100", bus.pc, 64'h100);
    check("cb_hit", bus.btb_hit, 1'b1);
    check("cb_pred", bus.pred_next, 64'hF8);
    drive(1'b1, BR_COND, 64'h100, 64'hF8, 1'b0, 19'h7FFFE, '0, '0);
    #1;
    check("cnt_flush", bus.flush, 1'b1);
    check("cnt_prehit", bus.btb_hit, 1'b1);
    step();
    idle();
    check("cnt_pc", bus.pc, 64'h104);
    check("cnt_cnt", bus.mispredict_cnt, 32'd4);
    drive_br(64'h304, 64'h100, 64'h0);
    step();
    idle();
    check("inv_pc", bus.pc, 64'h100);
    check("inv_hit", bus.btb_hit, 1'b0);
    check("inv_pred", bus.pred_next, 64'h104);

    // Stall holds; a flush overrides stall
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", bus.pc, 64'h100);
    end
    drive_br(64'h500, 64'h800, 64'h504);
    #1;
    check("stall_flush", bus.flush, 1'b1);
    step();
    idle();
    check("stall_redir", bus.pc, 64'h800);
    check("stall_cnt", bus.mispredict_cnt, 32'd6);
    step();
    check("stall_hold2", bus.pc, 64'h800);

    // Table-driven resolve vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].mode, vecs[i].rpc, vecs[i].pred, vecs[i].tk,
            vecs[i].i19, vecs[i].i26, vecs[i].db);
      #1;
      check($sformatf("vec%0d_flush", i), bus.flush, vecs[i].exp_flush);
      step();
      check($sformatf("vec%0d_pc", i), bus.pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_cnt", i), bus.mispredict_cnt, vecs[i].exp_cnt);
    end
    idle();

    // Confirm 0x10 entry survived, park at 0x80, then reset asynchronously
    drive_br(64'h600, 64'h10, 64'h0);
    step();
    idle();
    check("pre_rst_pc", bus.pc, 64'h10);
    check("pre_rst_hit", bus.btb_hit, 1'b1);
    drive_br(64'h700, 64'h80, 64'h0);
    step();
    idle();
    check("pre_rst_pc80", bus.pc, 64'h80);
    check("pre_rst_cnt", bus.mispredict_cnt, 32'd13);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_pc", bus.pc, 64'h0);
    check("async_cnt", bus.mispredict_cnt, 32'h0);
    check("async_hit", bus.btb_hit, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus.stall = 1'b0;
    step();
    check("post_rst_pc", bus.pc, 64'h4);
    drive_br(64'h900, 64'h10, 64'h0);
    step();
    idle();
    check("post_rst_fetch", bus.pc, 64'h10);
    check("post_rst_hit", bus.btb_hit, 1'b0);
    check("post_rst_pred", bus.pred_next, 64'h14);
    check("post_rst_cnt", bus.mispredict_cnt, 32'd1);

    // Counter saturation on the 2-bit instance
    bus2.res_valid = 1'b1;
    bus2.res_mode  = BR_REG;
    bus2.res_pc    = 64'h900;
    bus2.res_db    = 64'h40;
    bus2.res_pred_next = 64'h0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("sat_cnt%0d", i), 64'(bus2.mispredict_cnt), (i < 3) ? 64'(i) : 64'd3);
    end
    bus2.res_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
